sd_spi_host: RTL

//  SPI-mode SD host (initiator) for our SD card responder. Takes a 48-bit command, shifts it out MSB-first, then clocks in the response.
//  For CMD17 it also clocks in the 48-bit token phase and one 48-bit data word.

---
 rtl/sd_spi_host_if.sv | 27 ++
 rtl/sd_spi_host.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_host_if.sv
// Command/response bus between the system controller and the SPI-mode SD host.
// The controller side uses the master modport, the host uses the slave modport.
interface sd_spi_host_if;
    logic [47:0] cmd_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [47:0] resp_out;
    logic        resp_valid;
    logic [47:0] rd_data_out;
    logic        rd_data_valid;
    logic        token_err;
    logic        busy;
    logic [15:0] txn_count;
    logic [15:0] err_count;

    modport master (
        output cmd_in, cmd_valid,
        input  cmd_ready, resp_out, resp_valid, rd_data_out, rd_data_valid,
        input  token_err, busy, txn_count, err_count
    );

    modport slave (
        input  cmd_in, cmd_valid,
        output cmd_ready, resp_out, resp_valid, rd_data_out, rd_data_valid,
        output token_err, busy, txn_count, err_count
    );
endinterface

// File: rtl/sd_spi_host.sv
// SPI-mode (mode 0) SD host: shifts out a 48-bit command, captures a 48-bit
// response and, for CMD17, a 48-bit token phase followed by one data word.
// Optional feature macro: SD_HOST_STATS_EN builds saturating transaction and
// token-error counters; without it both counters read as zero.
module sd_spi_host #(
    parameter int         SCLK_HALF  = 4,
    parameter int         CS_GAP     = 4,
    parameter logic [7:0] DATA_TOKEN = 8'hFE
) (
    input  logic         clk,
    input  logic         rst_n,
    sd_spi_host_if.slave bus,
    output logic         cs_n,
    output logic         sclk,
    output logic         mosi,
    input  logic         miso
);
    localparam int DIV_W = $clog2(SCLK_HALF);
    localparam int GAP_W = $clog2(CS_GAP);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {IDLE, CMD, RESP, TOKEN, DATA, GAP} state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div;
    logic [GAP_W-1:0] gap_cnt;
    logic [5:0]       bit_cnt;
    logic             tail;
    logic             is_read;
    logic             token_ok;
    logic [6:0]       token_sh;
    logic [47:0]      tx_sh;
    logic [47:0]      resp_out;
    logic [47:0]      rd_data_out;
    logic             resp_valid;
    logic             rd_data_valid;
    logic             token_err;

    logic in_xfer, tick, rise, fall, done, last;

    // A half-period ends every SCLK_HALF clocks; once the final bit of a
    // phase is in, the next low-ending tick closes the frame instead of rising.
    assign in_xfer = (state == CMD) || (state == RESP) || (state == TOKEN) || (state == DATA);
    assign tick    = in_xfer && (div == DIV_LAST);
    assign rise    = tick && !sclk && !tail;
    assign fall    = tick && sclk;
    assign done    = tick && !sclk && tail;
    assign last    = (bit_cnt == 6'd47);

    assign bus.cmd_ready     = (state == IDLE);
    assign bus.busy          = (state != IDLE);
    assign bus.resp_out      = resp_out;
    assign bus.resp_valid    = resp_valid;
    assign bus.rd_data_out   = rd_data_out;
    assign bus.rd_data_valid = rd_data_valid;
    assign bus.token_err     = token_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Phase sequencing driven by the sclk edge strobes.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_next = CMD;
            CMD:     if (fall && last) state_next = RESP;
            RESP: begin
                if (rise && last && is_read) state_next = TOKEN;
                else if (done)               state_next = GAP;
            end
            TOKEN:   if (rise && last) state_next = DATA;
            DATA:    if (done) state_next = GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pin timing, shift registers, bit counting and result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div           <= '0;
            gap_cnt       <= '0;
            bit_cnt       <= '0;
            tail          <= 1'b0;
            is_read       <= 1'b0;
            token_ok      <= 1'b0;
            token_sh      <= '0;
            tx_sh         <= '0;
            resp_out      <= '0;
            rd_data_out   <= '0;
            resp_valid    <= 1'b0;
            rd_data_valid <= 1'b0;
            token_err     <= 1'b0;
            cs_n          <= 1'b1;
            sclk          <= 1'b0;
            mosi          <= 1'b1;
        end else begin
            resp_valid    <= 1'b0;
            rd_data_valid <= 1'b0;
            token_err     <= 1'b0;
            if (!in_xfer || tick) div <= '0;
            else                  div <= div + DIV_W'(1);
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        tx_sh   <= bus.cmd_in;
                        is_read <= (bus.cmd_in[47:40] == 8'h51);
                        cs_n    <= 1'b0;
                        sclk    <= 1'b0;
                        mosi    <= bus.cmd_in[47];
                        bit_cnt <= '0;
                        tail    <= 1'b0;
                    end
                end
                CMD: begin
                    if (rise) sclk <= 1'b1;
                    if (fall) begin
                        sclk <= 1'b0;
                        if (last) begin
                            mosi    <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            mosi    <= tx_sh[46];
                            tx_sh   <= tx_sh << 1;
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                RESP: begin
                    if (rise) begin
                        sclk     <= 1'b1;
                        resp_out <= {resp_out[46:0], miso};
                        bit_cnt  <= bit_cnt + 6'd1;
                        if (last) begin
                            if (is_read) begin
                                resp_valid <= 1'b1;
                                bit_cnt    <= '0;
                            end else begin
                                tail <= 1'b1;
                            end
                        end
                    end
                    if (fall) sclk <= 1'b0;
                    if (done) begin
                        cs_n       <= 1'b1;
                        tail       <= 1'b0;
                        gap_cnt    <= '0;
                        resp_valid <= 1'b1;
                    end
                end
                TOKEN: begin
                    if (rise) begin
                        sclk     <= 1'b1;
                        token_sh <= {token_sh[5:0], miso};
                        bit_cnt  <= bit_cnt + 6'd1;
                        if (last) begin
                            bit_cnt  <= '0;
                            token_ok <= ({token_sh, miso} == DATA_TOKEN);
                        end
                    end
                    if (fall) sclk <= 1'b0;
                end
                DATA: begin
                    if (rise) begin
                        sclk        <= 1'b1;
                        rd_data_out <= {rd_data_out[46:0], miso};
                        bit_cnt     <= bit_cnt + 6'd1;
                        if (last) tail <= 1'b1;
                    end
                    if (fall) sclk <= 1'b0;
                    if (done) begin
                        cs_n          <= 1'b1;
                        tail          <= 1'b0;
                        gap_cnt       <= '0;
                        rd_data_valid <= token_ok;
                        token_err     <= !token_ok;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                    cs_n    <= 1'b1;
                    sclk    <= 1'b0;
                    mosi    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SD_HOST_STATS_EN
    logic [15:0] txn_count, err_count;

    // Saturating counts of completed transactions and read-token errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
            err_count <= '0;
        end else begin
            if (done && txn_count != 16'hFFFF) txn_count <= txn_count + 16'd1;
            if (done && state == DATA && !token_ok && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end

    assign bus.txn_count = txn_count;
    assign bus.err_count = err_count;
`else
    assign bus.txn_count = '0;
    assign bus.err_count = '0;
`endif
endmodule
